// File: rtl/mem_bus_stage.sv
// MEM pipeline stage: passes ALU and HI/LO results through to mem_wb, and runs one
// req/ack bus transaction per aligned load/store, with big-endian lanes.
module mem_bus_stage #(
    parameter int DW  = 32,
    parameter int AW  = 32,
    parameter int OPW = 8,
    parameter int RAW = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [RAW-1:0] mem_wd,
    input  logic           mem_wreg,
    input  logic [DW-1:0]  mem_wdata,
    input  logic [DW-1:0]  mem_hi,
    input  logic [DW-1:0]  mem_lo,
    input  logic           mem_whilo,
    input  logic [OPW-1:0] mem_aluop,
    input  logic [DW-1:0]  mem_mem_addr,
    input  logic [DW-1:0]  mem_reg2,
    input  logic [5:0]     stall,
    input  logic [DW-1:0]  bus_rdata,
    input  logic           bus_ack,
    output logic           bus_req,
    output logic           bus_we,
    output logic [AW-1:0]  bus_addr,
    output logic [3:0]     bus_sel,
    output logic [DW-1:0]  bus_wdata,
    output logic           stallreq,
    output logic           align_err,
    output logic [RAW-1:0] wb_wd,
    output logic           wb_wreg,
    output logic [DW-1:0]  wb_wdata,
    output logic [DW-1:0]  wb_hi,
    output logic [DW-1:0]  wb_lo,
    output logic           wb_whilo
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    state_t state_q, state_d;

    logic          req_q, we_q;
    logic [AW-1:0] addr_q;
    logic [3:0]    sel_q, sel_c;
    logic [DW-1:0] wdata_q, wdata_c, rbuf_q, load_c;
    logic [7:0]    byte_c;
    logic [15:0]   half_c;
    logic          is_load, is_store, is_byte, is_half, is_signed, misalign, go;
    logic [1:0]    a;
    logic          unused_stall;

    assign a            = mem_mem_addr[1:0];
    assign unused_stall = ^{stall[5], stall[3:0]};

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_byte   = 1'b0;
        is_half   = 1'b0;
        is_signed = 1'b0;
        case (mem_aluop)
            OPW'(8'hE0): begin is_load = 1'b1; is_byte = 1'b1; is_signed = 1'b1; end
            OPW'(8'hE1): begin is_load = 1'b1; is_half = 1'b1; is_signed = 1'b1; end
            OPW'(8'hE3): is_load = 1'b1;
            OPW'(8'hE4): begin is_load = 1'b1; is_byte = 1'b1; end
            OPW'(8'hE5): begin is_load = 1'b1; is_half = 1'b1; end
            OPW'(8'hE8): begin is_store = 1'b1; is_byte = 1'b1; end
            OPW'(8'hE9): begin is_store = 1'b1; is_half = 1'b1; end
            OPW'(8'hEB): is_store = 1'b1;
            default: ;
        endcase
    end

    assign misalign = (is_load | is_store) &
                      (is_byte ? 1'b0 : (is_half ? a[0] : (a != 2'b00)));
    assign go       = (is_load | is_store) & ~misalign;

    // Lane select and lane-replicated store data, bit3 of sel = bits[31:24]
    always_comb begin
        sel_c   = 4'b1111;
        wdata_c = mem_reg2;
        if (is_byte) begin
            sel_c   = 4'b1000 >> a;
            wdata_c = {4{mem_reg2[7:0]}};
        end else if (is_half) begin
            sel_c   = a[1] ? 4'b0011 : 4'b1100;
            wdata_c = {2{mem_reg2[15:0]}};
        end
    end

    always_comb begin
        case (a)
            2'd0:    byte_c = rbuf_q[31:24];
            2'd1:    byte_c = rbuf_q[23:16];
            2'd2:    byte_c = rbuf_q[15:8];
            default: byte_c = rbuf_q[7:0];
        endcase
        half_c = a[1] ? rbuf_q[15:0] : rbuf_q[31:16];
        if (is_byte)      load_c = {{24{is_signed & byte_c[7]}}, byte_c};
        else if (is_half) load_c = {{16{is_signed & half_c[15]}}, half_c};
        else              load_c = rbuf_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (go)       state_d = S_BUSY;
            S_BUSY:  if (bus_ack)  state_d = S_DONE;
            S_DONE:  if (!stall[4]) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus side is registered; fields stay frozen from issue until ack
    always_ff @(posedge clk) begin
        if (!rst) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            sel_q   <= '0;
            wdata_q <= '0;
            rbuf_q  <= '0;
        end else if (state_q == S_IDLE && go) begin
            req_q   <= 1'b1;
            we_q    <= is_store;
            addr_q  <= AW'({mem_mem_addr[DW-1:2], 2'b00});
            sel_q   <= sel_c;
            wdata_q <= wdata_c;
        end else if (state_q == S_BUSY && bus_ack) begin
            req_q  <= 1'b0;
            rbuf_q <= bus_rdata;
        end
    end

    assign bus_req   = req_q;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_sel   = sel_q;
    assign bus_wdata = wdata_q;

    always_comb begin
        wb_wd     = mem_wd;
        wb_wreg   = mem_wreg;
        wb_wdata  = mem_wdata;
        wb_hi     = mem_hi;
        wb_lo     = mem_lo;
        wb_whilo  = mem_whilo;
        stallreq  = 1'b0;
        align_err = 1'b0;
        if (!rst) begin
            wb_wd    = '0;
            wb_wreg  = 1'b0;
            wb_wdata = '0;
            wb_hi    = '0;
            wb_lo    = '0;
            wb_whilo = 1'b0;
        end else begin
            align_err = misalign;
            stallreq  = (state_q == S_IDLE && go) || state_q == S_BUSY;
            if (is_load | is_store) begin
                wb_wreg = 1'b0;
                if (state_q == S_DONE && is_load) begin
                    wb_wreg  = mem_wreg;
                    wb_wdata = load_c;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_bus_stage.sv
// Randomized bench for mem_bus_stage against a transaction-level model of the MEM stage.
module tb_mem_bus_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mem_wd;
    logic        mem_wreg, mem_whilo, bus_ack;
    logic [31:0] mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_reg2, bus_rdata;
    logic [7:0]  mem_aluop;
    logic [5:0]  stall;
    logic        bus_req, bus_we, stallreq, align_err, wb_wreg, wb_whilo;
    logic [31:0] bus_addr, bus_wdata, wb_wdata, wb_hi, wb_lo;
    logic [3:0]  bus_sel;
    logic [4:0]  wb_wd;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_bus_stage dut (
        .clk(clk), .rst(rst), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo), .mem_aluop(mem_aluop),
        .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2), .stall(stall),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_sel(bus_sel), .bus_wdata(bus_wdata), .stallreq(stallreq),
        .align_err(align_err), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One instruction presented to the stage; returns with the stage back in IDLE
    task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                          input logic [31:0] wd, input logic wr, input int nwait,
                          input logic [31:0] rd, input int hold);
        logic ld, st, mis, hw, wo;
        int ai, sc, rc;
        logic [31:0] b, h, expv, exp_wdata;
        logic [3:0] exp_sel, s8, s12;
        ld = op inside {8'hE0, 8'hE1, 8'hE3, 8'hE4, 8'hE5};
        st = op inside {8'hE8, 8'hE9, 8'hEB};
        hw = op inside {8'hE1, 8'hE5, 8'hE9};
        wo = op inside {8'hE3, 8'hEB};
        ai = int'(addr[1:0]);
        mis = (hw && addr[0]) || (wo && addr[1:0] != 2'b00);
        s8 = 4'b1000; s12 = 4'b1100;
        exp_sel   = hw ? (s12 >> ai) : (wo ? 4'b1111 : (s8 >> ai));
        exp_wdata = hw ? {2{reg2[15:0]}} : (wo ? reg2 : {4{reg2[7:0]}});
        b = rd >> (8 * (3 - ai));
        h = rd >> (16 * (1 - ai / 2));
        case (op)
            8'hE0:   expv = {{24{b[7]}}, b[7:0]};
            8'hE4:   expv = {24'h0, b[7:0]};
            8'hE1:   expv = {{16{h[15]}}, h[15:0]};
            8'hE5:   expv = {16'h0, h[15:0]};
            default: expv = rd;
        endcase

        mem_aluop = op; mem_mem_addr = addr; mem_reg2 = reg2; mem_wdata = wd; mem_wreg = wr;
        mem_wd = 5'($urandom); mem_hi = $urandom; mem_lo = $urandom; mem_whilo = 1'($urandom);
        stall = 6'($urandom) & 6'b101111; bus_ack = 1'($urandom); bus_rdata = $urandom;
        @(negedge clk);
        chk("wb_hi", wb_hi, mem_hi);
        chk("wb_lo", wb_lo, mem_lo);
        chk("wb_whilo", wb_whilo, mem_whilo);
        chk("wb_wd", wb_wd, mem_wd);
        chk("align_err", align_err, mis);
        if (!(ld | st) || mis) begin
            chk("stallreq_idle", stallreq, 1'b0);
            chk("wb_wreg_idle", wb_wreg, (ld | st) ? 1'b0 : wr);
            if (!(ld | st)) chk("wb_wdata_pass", wb_wdata, wd);
            @(posedge clk); #1;
            chk("bus_req_none", bus_req, 1'b0);
            return;
        end
        chk("stallreq_issue", stallreq, 1'b1);
        chk("wb_wreg_issue", wb_wreg, 1'b0);
        sc = 1; rc = 0;
        for (int c = 0; c < 64; c++) begin
            @(posedge clk); #1;
            bus_ack   = (c == nwait);
            bus_rdata = (c == nwait) ? rd : $urandom;
            @(negedge clk);
            if (!stallreq) break;
            sc++;
            if (bus_req) rc++;
            if (c == 0) begin
                chk("bus_we", bus_we, st);
                chk("bus_addr", bus_addr, {addr[31:2], 2'b00});
                chk("bus_sel", bus_sel, exp_sel);
                if (st) chk("bus_wdata", bus_wdata, exp_wdata);
            end
        end
        chk("stall_cycles", sc, nwait + 2);
        chk("req_cycles", rc, nwait + 1);
        chk("bus_req_done", bus_req, 1'b0);
        chk("wb_wreg_done", wb_wreg, ld ? wr : 1'b0);
        if (ld) chk("load_data", wb_wdata, expv);
        for (int k = 0; k < hold; k++) begin
            stall = 6'b010000;
            @(posedge clk); #1;
            bus_ack = 1'($urandom); bus_rdata = $urandom;
            @(negedge clk);
            chk("hold_req", bus_req, 1'b0);
            chk("hold_stallreq", stallreq, 1'b0);
            if (ld) chk("hold_data", wb_wdata, expv);
        end
        stall = 6'b000000;
        @(posedge clk); #1;
        bus_ack = 1'b0;
    endtask

    logic [7:0] ops [10];

    initial begin
        ops = '{8'hE0, 8'hE1, 8'hE3, 8'hE4, 8'hE5, 8'hE8, 8'hE9, 8'hEB, 8'h20, 8'h21};
        rst = 1'b0; stall = '0; bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
        mem_aluop = 8'hE3; mem_mem_addr = 32'h100; mem_reg2 = 32'h55; mem_wdata = 32'h77;
        mem_wreg = 1'b1; mem_wd = 5'd3; mem_hi = 32'h1; mem_lo = 32'h2; mem_whilo = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", bus_req, 1'b0);
        chk("rst_we", bus_we, 1'b0);
        chk("rst_addr", bus_addr, 32'h0);
        chk("rst_sel", bus_sel, 4'h0);
        chk("rst_wdata", bus_wdata, 32'h0);
        chk("rst_stallreq", stallreq, 1'b0);
        chk("rst_wb", {wb_wreg, wb_wdata, wb_whilo, wb_wd}, 64'h0);
        chk("rst_hilo", {wb_hi, wb_lo}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b1; bus_ack = 1'b0;

        run_op(8'h20, 32'h0, 32'h0, 32'h1234, 1'b1, 0, 32'h0, 0);
        run_op(8'hE0, 32'h101, 32'h0, 32'h9, 1'b1, 2, 32'h11F23344, 0);
        run_op(8'hE4, 32'h101, 32'h0, 32'h9, 1'b1, 2, 32'h11F23344, 0);
        run_op(8'hE9, 32'h102, 32'hAAAABEEF, 32'h9, 1'b1, 0, 32'h0, 0);
        run_op(8'hE3, 32'h102, 32'h0, 32'h9, 1'b1, 0, 32'h0, 0);
        run_op(8'hE3, 32'h104, 32'h0, 32'h9, 1'b1, 1, 32'hCAFEF00D, 3);

        // Reset while BUSY, then the same load must issue afresh
        mem_aluop = 8'hE3; mem_mem_addr = 32'h200; mem_wdata = 32'h99; mem_wreg = 1'b1;
        stall = '0; bus_ack = 1'b0;
        @(posedge clk); #1;
        chk("busy_req", bus_req, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_stallreq", stallreq, 1'b0);
        chk("midrst_wb", {wb_wreg, wb_wdata}, 64'h0);
        chk("midrst_align", align_err, 1'b0);
        @(posedge clk); #1;
        chk("midrst_req", bus_req, 1'b0);
        rst = 1'b1;
        run_op(8'hE3, 32'h200, 32'h0, 32'h99, 1'b1, 0, 32'h87654321, 0);

        for (int i = 0; i < 80; i++) begin
            logic [7:0] op;
            op = ops[$urandom_range(9)];
            if (op == 8'h21) op = 8'($urandom);
            run_op(op, $urandom, $urandom, $urandom, 1'($urandom), $urandom_range(3),
                   $urandom, $urandom_range(2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
